instruction_fetch: RTL and testbench

Fetch stage sitting directly downstream of `program_counter`. It reads the current 15-bit PC and issues a read to instruction ROM, which may insert wait states. It latches the returned 16-bit instruction and presents it to the CPU decode stage over a valid/ready handshake. It also drives the counter's `inc`/`load`/`in` inputs, covering sequential advance, jump redirects and boot-to-zero.

---
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: drives program_counter, reads instruction ROM, hands instructions to decode
module instruction_fetch #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_out,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_in,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic                r_instr_valid;

    state_t              w_next;
    logic                w_pc_inc;
    logic                w_pc_load;
    logic [ADDR_W-1:0]   w_pc_in;
    logic                w_rom_req;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic                w_capture;
    logic                w_clear;

    always_comb begin
        w_next     = r_state;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_in    = '0;
        w_rom_req  = 1'b0;
        w_rom_addr = '0;
        w_capture  = 1'b0;
        w_clear    = 1'b0;

        case (r_state)
            S_BOOT: begin
                // Force the PC to zero independent of the counter's own reset value.
                w_pc_load = 1'b1;
                w_next    = S_FETCH;
            end
            S_FETCH: begin
                w_rom_addr = pc_out;
                if (redirect) begin
                    w_pc_load = 1'b1;
                    w_pc_in   = redirect_addr;
                    w_clear   = 1'b1;
                end else begin
                    w_rom_req = 1'b1;
                    if (rom_ack) begin
                        w_capture = 1'b1;
                        w_pc_inc  = 1'b1;
                        w_next    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A redirect drops the held instruction whether or not decode took it this cycle.
                if (redirect) begin
                    w_pc_load = 1'b1;
                    w_pc_in   = redirect_addr;
                    w_clear   = 1'b1;
                    w_next    = S_FETCH;
                end else if (instr_ready) begin
                    w_clear = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            default: begin
                w_next = S_BOOT;
            end
        endcase

        if (!rst) begin
            w_next     = S_BOOT;
            w_pc_inc   = 1'b0;
            w_pc_load  = 1'b0;
            w_pc_in    = '0;
            w_rom_req  = 1'b0;
            w_rom_addr = '0;
            w_capture  = 1'b0;
            w_clear    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_instr       <= rom_data;
                r_instr_pc    <= pc_out;
                r_instr_valid <= 1'b1;
            end else if (w_clear) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign pc_inc      = w_pc_inc;
    assign pc_load     = w_pc_load;
    assign pc_in       = w_pc_in;
    assign rom_req     = w_rom_req;
    assign rom_addr    = w_rom_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch with PC and ROM models
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] pc_out;
    logic        pc_inc;
    logic        pc_load;
    logic [14:0] pc_in;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [14:0] redirect_addr;

    int total = 0;
    int bad   = 0;

    logic [14:0] pc_m = 15'h5A5A;
    logic [3:0]  wcnt = 4'd0;
    logic [3:0]  wait_n;
    logic        ack_noise;
    logic        ack_force;
    int          transfers = 0;

    instruction_fetch #(.ADDR_W(15), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_in(pc_in), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_addr(redirect_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    // program_counter model: registered, wraps at 15 bits, own reset value is arbitrary
    always @(posedge clk) begin
        if (!rst)          pc_m <= 15'($urandom);
        else if (pc_load)  pc_m <= pc_in;
        else if (pc_inc)   pc_m <= pc_m + 15'd1;
    end
    assign pc_out = pc_m;

    // ROM model: data = addr ^ 0x1234, ack after wait_n cycles of continuous request
    always @(posedge clk) begin
        if (!rom_req || rom_ack) wcnt <= 4'd0;
        else                     wcnt <= wcnt + 4'd1;
    end
    assign rom_data = {1'b0, rom_addr} ^ 16'h1234;
    assign rom_ack  = ack_force | (rom_req ? (wcnt >= wait_n) : ack_noise);

    // Reference model: the next instruction decode should see, checked every cycle
    initial begin : monitor
        bit          boot_pend = 0;
        bit          p_rst = 1;
        bit          p_boot = 0, p_ack = 0, p_redir = 0, p_xfer = 0, p_hold = 0;
        logic [15:0] p_instr = '0;
        logic [14:0] p_ipc = '0;
        logic [14:0] exp_pc = '0;
        bit          boot, rd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_ctl", {29'd0, pc_inc, pc_load, rom_req}, 32'd0);
                chk("rst_addr", {2'd0, pc_in, rom_addr}, 32'd0);
                if (!p_rst) chk("rst_regs", {instr_valid, instr, instr_pc}, 32'd0);
                boot_pend = 1;
                {p_boot, p_ack, p_redir, p_xfer, p_hold} = '0;
            end else begin
                boot = boot_pend;
                boot_pend = 0;
                rd = redirect && !boot;
                chk("inc_and_load", {31'd0, pc_inc & pc_load}, 32'd0);
                chk("pc_load", {31'd0, pc_load}, {31'd0, boot | rd});
                if (pc_load) chk("pc_in", {17'd0, pc_in}, boot ? 32'd0 : {17'd0, redirect_addr});
                if (boot || rd) chk("req_quiet", {31'd0, rom_req}, 32'd0);
                if (boot) chk("boot_valid", {31'd0, instr_valid}, 32'd0);
                chk("pc_inc_on_ack", {31'd0, pc_inc}, {31'd0, rom_req & rom_ack});
                if (rom_req) begin
                    chk("rom_addr", {17'd0, rom_addr}, {17'd0, pc_m});
                    chk("req_valid_excl", {31'd0, instr_valid}, 32'd0);
                end
                if (instr_valid) begin
                    chk("instr_pc", {17'd0, instr_pc}, {17'd0, exp_pc});
                    chk("instr", {16'd0, instr}, {16'd0, {1'b0, exp_pc} ^ 16'h1234});
                end
                if (p_rst) begin
                    if (p_ack) chk("fetch_latency", {31'd0, instr_valid}, 32'd1);
                    if (p_boot || p_redir || p_xfer) begin
                        chk("after_drop_valid", {31'd0, instr_valid}, 32'd0);
                        chk("after_drop_req", {31'd0, rom_req}, {31'd0, !redirect});
                    end
                    if (p_hold) begin
                        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                        chk("hold_stable", {1'b0, instr, instr_pc}, {1'b0, p_instr, p_ipc});
                    end
                end
                p_boot  = boot;
                p_ack   = rom_req && rom_ack;
                p_redir = rd;
                p_xfer  = instr_valid && instr_ready;
                p_hold  = instr_valid && !instr_ready && !rd;
                p_instr = instr;
                p_ipc   = instr_pc;
                if (instr_valid && instr_ready) begin
                    exp_pc = exp_pc + 15'd1;
                    transfers++;
                end
                if (rd)   exp_pc = redirect_addr;
                if (boot) exp_pc = '0;
            end
            p_rst = rst;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
        wait_n = 4'd0; ack_noise = 1'b0; ack_force = 1'b0;
        cyc(); cyc();
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b1;

        smp();
        chk("boot_load", {31'd0, pc_load}, 32'd1);
        chk("boot_pc_in", {17'd0, pc_in}, 32'd0);
        chk("boot_req", {31'd0, rom_req}, 32'd0);
        cyc();

        for (int k = 0; k < 6; k++) begin
            smp();
            chk("stream_valid", {31'd0, instr_valid}, k % 2);
            if (k == 0) chk("first_addr", {17'd0, rom_addr}, 32'd0);
            if (k % 2 == 1) begin
                chk("stream_pc", {17'd0, instr_pc}, k / 2);
                chk("stream_instr", {16'd0, instr}, 32'h1234 ^ (k / 2));
            end
            cyc();
        end

        wait_n = 4'd3;
        for (int j = 0; j < 4; j++) begin
            smp();
            chk("wait_req", {31'd0, rom_req}, 32'd1);
            chk("wait_addr", {17'd0, rom_addr}, 32'd3);
            chk("wait_inc", {31'd0, pc_inc}, (j == 3) ? 32'd1 : 32'd0);
            cyc();
        end
        smp();
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
        chk("wait_pc", {17'd0, instr_pc}, 32'd3);
        cyc();

        instr_ready = 1'b0; wait_n = 4'd0;
        smp(); cyc();
        for (int j = 0; j < 5; j++) begin
            smp();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr", {16'd0, instr}, 32'h1234 ^ 4);
            chk("bp_req", {31'd0, rom_req}, 32'd0);
            chk("bp_inc", {31'd0, pc_inc}, 32'd0);
            cyc();
        end
        instr_ready = 1'b1; wait_n = 4'd3;
        smp(); cyc();
        smp();
        chk("bp_resume_req", {31'd0, rom_req}, 32'd1);
        chk("bp_resume_addr", {17'd0, rom_addr}, 32'd5);
        cyc();

        redirect = 1'b1; redirect_addr = 15'h2BCD; ack_force = 1'b1;
        smp();
        chk("rd_load", {31'd0, pc_load}, 32'd1);
        chk("rd_pc_in", {17'd0, pc_in}, 32'h2BCD);
        chk("rd_inc", {31'd0, pc_inc}, 32'd0);
        chk("rd_req", {31'd0, rom_req}, 32'd0);
        cyc();
        redirect = 1'b0; ack_force = 1'b0; wait_n = 4'd0;
        smp();
        chk("rd_target_req", {31'd0, rom_req}, 32'd1);
        chk("rd_target_addr", {17'd0, rom_addr}, 32'h2BCD);
        chk("rd_no_old", {31'd0, instr_valid}, 32'd0);
        cyc();
        smp();
        chk("rd_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_instr_pc", {17'd0, instr_pc}, 32'h2BCD);
        cyc();

        redirect = 1'b1; redirect_addr = 15'h7FFF;
        smp(); cyc();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            if (i == 1) chk("wrap_pc0", {17'd0, instr_pc}, 32'h7FFF);
            if (i == 3) chk("wrap_pc1", {17'd0, instr_pc}, 32'h0000);
            if (i % 2 == 1) chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
            cyc();
        end

        wait_n = 4'd5;
        cyc();
        rst = 1'b0;
        smp();
        chk("mid_rst_req", {31'd0, rom_req}, 32'd0);
        chk("mid_rst_addr", {17'd0, rom_addr}, 32'd0);
        cyc();
        smp();
        chk("mid_rst_regs", {instr_valid, instr, instr_pc}, 32'd0);
        cyc();
        rst = 1'b1;
        smp();
        chk("mid_rst_boot", {31'd0, pc_load}, 32'd1);
        cyc();
        smp();
        chk("mid_rst_fetch", {18'd0, rom_req, rom_addr}, 32'h8000);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) != 0);
            instr_ready   = ($urandom_range(0, 9) < 7);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_addr = ($urandom_range(0, 3) == 0) ? 15'h7FFF : 15'($urandom);
            wait_n        = 4'($urandom_range(0, 3));
            ack_noise     = 1'($urandom);
            ack_force     = ($urandom_range(0, 29) == 0);
            cyc();
        end
        rst = 1'b1; redirect = 1'b0; ack_force = 1'b0;
        smp();
        chk("progress", {31'd0, transfers > 300}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
